// File: rtl/gru_feeder_pkg.sv
// Shared types and default sizing for the GRU sequence feeder.
package gru_feeder_pkg;

    localparam int unsigned X_SIZE         = 6;
    localparam int unsigned WIDTH          = 16;
    localparam int unsigned SEQ_LEN        = 15;
    localparam int unsigned STEP_CYCLES    = 19;
    localparam int unsigned RESULT_SIZE    = 3;
    localparam int unsigned RESULT_LATENCY = 12;

    // Read-side sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StHold
    } rd_state_t;

    typedef logic [X_SIZE-1:0][WIDTH-1:0]      feature_vec_t;
    typedef logic [RESULT_SIZE-1:0][WIDTH-1:0] result_vec_t;

endpackage

// File: rtl/seq_pingpong_buf.sv
// Two-bank sequence buffer: one write port, one asynchronous read port, and a
// full flag per bank. Bank contents are not reset; the flags alone decide
// whether a bank holds a valid sequence.
module seq_pingpong_buf #(
    parameter int unsigned X_SIZE  = gru_feeder_pkg::X_SIZE,
    parameter int unsigned WIDTH   = gru_feeder_pkg::WIDTH,
    parameter int unsigned SEQ_LEN = gru_feeder_pkg::SEQ_LEN,
    parameter int unsigned AW      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_wr_en,
    input  logic                         i_wr_bank,
    input  logic [AW-1:0]                i_wr_addr,
    input  logic [X_SIZE-1:0][WIDTH-1:0] i_wr_data,
    input  logic                         i_set_full,  // marks i_wr_bank full
    input  logic                         i_clr_full,  // frees i_rd_bank
    input  logic                         i_rd_bank,
    input  logic [AW-1:0]                i_rd_addr,
    output logic [X_SIZE-1:0][WIDTH-1:0] o_rd_data,
    output logic [1:0]                   o_full
);

    logic [X_SIZE-1:0][WIDTH-1:0] r_mem [2][SEQ_LEN];
    logic [1:0]                   r_full;

    // Storage write; no reset needed on the data array
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    // Full flags: writer sets its bank, reader frees its bank
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= '0;
        end else begin
            if (i_clr_full) begin
                r_full[i_rd_bank] <= 1'b0;
            end
            if (i_set_full) begin
                r_full[i_wr_bank] <= 1'b1;
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_bank][i_rd_addr];
    assign o_full    = r_full;

endmodule

// File: rtl/gru_seq_feeder.sv
// Feeds buffered jet sequences to the GRU top at a fixed per-step cadence and
// captures the model output as a single handshaked result beat.
module gru_seq_feeder #(
    parameter int unsigned X_SIZE         = gru_feeder_pkg::X_SIZE,
    parameter int unsigned WIDTH          = gru_feeder_pkg::WIDTH,
    parameter int unsigned SEQ_LEN        = gru_feeder_pkg::SEQ_LEN,
    parameter int unsigned STEP_CYCLES    = gru_feeder_pkg::STEP_CYCLES,
    parameter int unsigned RESULT_SIZE    = gru_feeder_pkg::RESULT_SIZE,
    parameter int unsigned RESULT_LATENCY = gru_feeder_pkg::RESULT_LATENCY
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [X_SIZE-1:0][WIDTH-1:0]      in_data,
    input  logic                              in_last,
    output logic [X_SIZE-1:0][WIDTH-1:0]      x_t,
    output logic                              seq_start,
    output logic [3:0]                        step_idx,
    output logic                              busy,
    input  logic [RESULT_SIZE-1:0][WIDTH-1:0] y_t,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [RESULT_SIZE-1:0][WIDTH-1:0] res_data,
    output logic                              seq_err
);
    import gru_feeder_pkg::*;

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned LW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [3:0]    STEP_LAST = 4'(SEQ_LEN - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RESULT_LATENCY - 1);

    // Write side
    logic       r_rdy_en;  // holds in_ready low until the first edge after reset
    logic       r_wr_bank, w_wr_bank_d;
    logic [3:0] r_wr_cnt, w_wr_cnt_d;
    logic       r_seq_err, w_seq_err_d;
    logic       w_fire, w_set_full;

    // Read side
    rd_state_t                        r_state, w_state_d;
    logic                             r_rd_bank, w_rd_bank_d;
    logic [CW-1:0]                    r_cyc, w_cyc_d;
    logic [3:0]                       r_step, w_step_d;
    logic [LW-1:0]                    r_lat, w_lat_d;
    logic [X_SIZE-1:0][WIDTH-1:0]     r_x, w_x_d;
    logic                             r_res_valid, w_res_valid_d;
    logic [RESULT_SIZE-1:0][WIDTH-1:0] r_res_data, w_res_data_d;
    logic                             w_seq_start, w_clr_full;
    logic [3:0]                       w_rd_addr;
    logic [X_SIZE-1:0][WIDTH-1:0]     w_rd_data;
    logic [1:0]                       w_full;

    seq_pingpong_buf #(
        .X_SIZE  (X_SIZE),
        .WIDTH   (WIDTH),
        .SEQ_LEN (SEQ_LEN),
        .AW      (4)
    ) u_buf (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_wr_en    (w_fire),
        .i_wr_bank  (r_wr_bank),
        .i_wr_addr  (r_wr_cnt),
        .i_wr_data  (in_data),
        .i_set_full (w_set_full),
        .i_clr_full (w_clr_full),
        .i_rd_bank  (r_rd_bank),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (w_rd_data),
        .o_full     (w_full)
    );

    assign in_ready = r_rdy_en & ~w_full[r_wr_bank];
    assign w_fire   = in_valid & in_ready;

    // Write-side next state: commit a well-formed sequence, drop a malformed one
    always_comb begin
        w_wr_bank_d = r_wr_bank;
        w_wr_cnt_d  = r_wr_cnt;
        w_set_full  = 1'b0;
        w_seq_err_d = 1'b0;
        if (w_fire) begin
            if (in_last && (r_wr_cnt == STEP_LAST)) begin
                w_set_full  = 1'b1;
                w_wr_bank_d = ~r_wr_bank;
                w_wr_cnt_d  = '0;
            end else if (in_last || (r_wr_cnt == STEP_LAST)) begin
                // Partial bank is abandoned; its full flag was never set
                w_seq_err_d = 1'b1;
                w_wr_cnt_d  = '0;
            end else begin
                w_wr_cnt_d = r_wr_cnt + 4'd1;
            end
        end
    end

    // Write-side state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_en  <= 1'b0;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_rdy_en  <= 1'b1;
            r_wr_bank <= w_wr_bank_d;
            r_wr_cnt  <= w_wr_cnt_d;
            r_seq_err <= w_seq_err_d;
        end
    end

    // Prefetch the vector for the upcoming step boundary
    assign w_rd_addr = ((r_state == StStream) && (r_step != STEP_LAST)) ? r_step + 4'd1 : 4'd0;

    // Read FSM next state and datapath loads
    always_comb begin
        w_state_d     = r_state;
        w_rd_bank_d   = r_rd_bank;
        w_cyc_d       = r_cyc;
        w_step_d      = r_step;
        w_lat_d       = r_lat;
        w_x_d         = r_x;
        w_res_valid_d = r_res_valid;
        w_res_data_d  = r_res_data;
        w_seq_start   = 1'b0;
        w_clr_full    = 1'b0;
        if (r_res_valid && res_ready) begin
            w_res_valid_d = 1'b0;
        end
        case (r_state)
            StIdle: begin
                // A held result blocks the next sequence from starting
                if (w_full[r_rd_bank] && !r_res_valid) begin
                    w_seq_start = 1'b1;
                    w_state_d   = StStream;
                    w_cyc_d     = '0;
                    w_step_d    = '0;
                    w_x_d       = w_rd_data;
                end
            end
            StStream: begin
                if (r_cyc == CYC_LAST) begin
                    w_cyc_d = '0;
                    if (r_step == STEP_LAST) begin
                        w_state_d   = StDrain;
                        w_step_d    = '0;
                        w_x_d       = '0;
                        w_lat_d     = '0;
                        w_clr_full  = 1'b1;
                        w_rd_bank_d = ~r_rd_bank;
                    end else begin
                        w_step_d = r_step + 4'd1;
                        w_x_d    = w_rd_data;
                    end
                end else begin
                    w_cyc_d = r_cyc + 1'b1;
                end
            end
            StDrain: begin
                if (r_lat == LAT_LAST) begin
                    w_res_data_d  = y_t;
                    w_res_valid_d = 1'b1;
                    w_state_d     = StHold;
                    w_lat_d       = '0;
                end else begin
                    w_lat_d = r_lat + 1'b1;
                end
            end
            StHold: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Read-side state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rd_bank   <= 1'b0;
            r_cyc       <= '0;
            r_step      <= '0;
            r_lat       <= '0;
            r_x         <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_rd_bank   <= w_rd_bank_d;
            r_cyc       <= w_cyc_d;
            r_step      <= w_step_d;
            r_lat       <= w_lat_d;
            r_x         <= w_x_d;
            r_res_valid <= w_res_valid_d;
            r_res_data  <= w_res_data_d;
        end
    end

    assign x_t       = r_x;
    assign seq_start = w_seq_start;
    assign step_idx  = r_step;
    assign busy      = (r_state == StStream) || (r_state == StDrain);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_gru_seq_feeder.sv
// Directed bench for gru_seq_feeder with a cycle-level stream monitor.
module tb_gru_seq_feeder;
    import gru_feeder_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         res_ready = 1'b1;
    logic         in_ready, seq_start, busy, res_valid, seq_err;
    logic [3:0]   step_idx;
    feature_vec_t in_data = '0;
    feature_vec_t x_t;
    result_vec_t  y_t = '0;
    result_vec_t  res_data;

    int n_tests = 0;
    int n_fail = 0;
    int n_to = 0;
    int cyc = 0;

    // Monitor state
    int n_start = 0, n_res = 0, n_err = 0, mon_err = 0, lat_err = 0;
    int last_start = 0, last_hs = 0, start_gap = 0, stream_left = 0, cur_id = 0, k = 0;
    int stable_err = 0;
    logic prev_rv = 1'b0;
    int exp_q[$];

    gru_seq_feeder u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .x_t       (x_t),
        .seq_start (seq_start),
        .step_idx  (step_idx),
        .busy      (busy),
        .y_t       (y_t),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: 285 stream cycles after seq_start, each vector held 19 cycles
    always @(negedge clk) begin
        if (reset) begin
            stream_left = 0;
            prev_rv = 1'b0;
        end else begin
            if (seq_start) begin
                n_start++;
                start_gap = cyc - last_hs;
                last_start = cyc;
                stream_left = 285;
                if (exp_q.size() == 0) mon_err++;
                else cur_id = exp_q.pop_front();
            end else if (stream_left > 0) begin
                k = (285 - stream_left) / 19;
                if (!busy || step_idx != 4'(k)) mon_err++;
                for (int j = 0; j < 6; j++) begin
                    if (x_t[j] !== 16'(cur_id * 256 + k * 16 + j)) mon_err++;
                end
                stream_left--;
            end else if (x_t !== '0) begin
                mon_err++;
            end
            if (res_valid && !prev_rv) begin
                n_res++;
                if (cyc - last_start != 298) lat_err++;
            end
            if (res_valid && res_ready) last_hs = cyc;
            if (seq_err) n_err++;
            prev_rv = res_valid;
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_beat(input int id, input int b, input bit last);
        int guard = 0;
        in_valid = 1'b1;
        in_last = last;
        for (int j = 0; j < 6; j++) in_data[j] = 16'(id * 256 + b * 16 + j);
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) n_to++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_seq(input int id, input int beats, input int last_at, input bit good);
        if (good) exp_q.push_back(id);
        for (int b = 0; b < beats; b++) push_beat(id, b, b == last_at);
    endtask

    task automatic wait_res(input int target);
        int guard = 0;
        while (n_res < target && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (n_res < target) n_to++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        y_t[0] = 16'd1;
        y_t[1] = 16'd2;
        y_t[2] = 16'd3;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_x_t", x_t, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_ctrl", {busy, seq_start, seq_err, step_idx}, 0);
        check("rst_res_data", res_data, 0);
        #10 reset = 1'b0;
        align();
        check("post_rst_in_ready", in_ready, 1);

        // One well-formed sequence
        send_seq(0, 15, 14, 1'b1);
        wait_res(1);
        check("t1_res_data", res_data, 48'h0003_0002_0001);
        check("t1_starts", n_start, 1);
        check("t1_latency_err", lat_err, 0);
        check("t1_stream_err", mon_err, 0);
        idle(1);
        check("t1_res_clear", {res_valid, busy}, 0);
        check("t1_seq_err", n_err, 0);

        // Two back-to-back sequences
        align();
        send_seq(1, 15, 14, 1'b1);
        send_seq(2, 15, 14, 1'b1);
        idle(1);
        check("t2_in_ready_low", in_ready, 0);
        check("t2_busy", busy, 1);
        wait_res(3);
        check("t2_starts", n_start, 3);
        check("t2_back_to_back_gap", start_gap, 1);
        check("t2_stream_err", mon_err, 0);
        check("t2_latency_err", lat_err, 0);
        check("t2_in_ready_high", in_ready, 1);

        // Early in_last on the 10th beat
        align();
        send_seq(3, 10, 9, 1'b0);
        idle(3);
        check("t3_seq_err_pulse", n_err, 1);
        check("t3_no_start", n_start, 3);
        check("t3_not_busy", busy, 0);
        align();
        send_seq(4, 15, 14, 1'b1);
        wait_res(4);
        check("t3_recover_starts", n_start, 4);
        check("t3_recover_stream_err", mon_err, 0);

        // Result held for 500 cycles with a second sequence queued
        align();
        res_ready = 1'b0;
        send_seq(5, 15, 14, 1'b1);
        send_seq(6, 15, 14, 1'b1);
        wait_res(5);
        for (int i = 0; i < 500; i++) begin
            if (i == 100) begin
                y_t[0] = 16'd7;
                y_t[1] = 16'd8;
                y_t[2] = 16'd9;
            end
            if (!res_valid || seq_start || res_data !== 48'h0003_0002_0001) stable_err++;
            idle(1);
        end
        check("t4_hold_stable", stable_err, 0);
        check("t4_no_second_start", n_start, 5);
        align();
        res_ready = 1'b1;
        align();
        res_ready = 1'b0;
        wait_res(6);
        check("t4_handshake_gap", start_gap, 1);
        check("t4_second_res_data", res_data, 48'h0009_0008_0007);
        check("t4_stream_err", mon_err, 0);
        res_ready = 1'b1;

        // Asynchronous reset during step 7
        align();
        send_seq(7, 15, 14, 1'b1);
        g = 0;
        while (step_idx != 4'd7 && g < 400) begin
            idle(1);
            g++;
        end
        if (step_idx != 4'd7) n_to++;
        reset = 1'b1;
        #1;
        check("t5_async_x_t", x_t, 0);
        check("t5_async_ctrl", {busy, seq_start, in_ready, res_valid, step_idx}, 0);
        align();
        align();
        reset = 1'b0;
        align();
        check("t5_in_ready", in_ready, 1);
        idle(5);
        check("t5_no_start_empty", n_start, 7);
        align();
        send_seq(8, 15, 14, 1'b1);
        wait_res(7);
        check("t5_fresh_starts", n_start, 8);
        check("t5_res_data", res_data, 48'h0009_0008_0007);
        check("t5_stream_err", mon_err, 0);
        check("t5_latency_err", lat_err, 0);

        // 16 beats, in_last only on the 16th: error on beat 15, and the
        // 16th beat is itself an early last for the new partial sequence
        align();
        send_seq(9, 16, 15, 1'b0);
        idle(3);
        check("t6_seq_err_count", n_err, 3);
        check("t6_no_start", n_start, 8);
        check("t6_in_ready", in_ready, 1);

        check("no_timeouts", n_to, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gru_seq_feeder.md
Name: gru_seq_feeder

Overview:
- Producer side of the GRU model input interface: accepts a jet's 15 feature vectors (6 x 16-bit each) over a valid/ready stream and buffers them in ping-pong banks.
- Replays each vector on a held x_t bus for STEP_CYCLES cycles, matching the fixed per-step cadence of the GRU top.
- After the last step plus a fixed pipeline latency, captures the model's y_t and presents it as one handshaked result beat.
- Sits between the upstream track/jet formatter and the GRU top.

Parameters:
- X_SIZE, 6, features per step
- SEQ_LEN, 15, steps per sequence
- WIDTH, 16, data width (Q5.10, NFRAC 10 upstream)
- STEP_CYCLES, 19, cycles each x_t vector is held
- RESULT_SIZE, 3, softmax outputs captured
- RESULT_LATENCY, 12, cycles from end of last step to valid y_t

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  feeder can accept vector
- in_data  in  X_SIZE x WIDTH  feature vector
- in_last  in  1  marks final vector of a sequence
- x_t  out  X_SIZE x WIDTH  vector driven to GRU
- seq_start  out  1  one-cycle pulse on first cycle of step 0
- step_idx  out  4  current step index
- busy  out  1  streaming or draining
- y_t  in  RESULT_SIZE x WIDTH  model output
- res_valid  out  1  captured result valid
- res_ready  in  1  downstream accepts result
- res_data  out  RESULT_SIZE x WIDTH  captured result
- seq_err  out  1  one-cycle pulse: malformed sequence dropped

Behaviour:
- Reset (async): all outputs 0; in_ready 0 while reset is asserted, 1 on the first cycle after; both banks empty; write and read FSMs idle. Reset mid-stream discards all buffered data and any pending result.
- Write side: wr_bank and wr_cnt. Transfer occurs when in_valid && in_ready. in_ready = (bank[wr_bank] empty).
- in_last with wr_cnt == SEQ_LEN-1: mark the bank full, toggle wr_bank, clear wr_cnt.
- in_last early, or wr_cnt == SEQ_LEN-1 without in_last: pulse seq_err, discard the partial bank and clear wr_cnt. The offending beat is consumed.
- Read FSM states: IDLE, STREAM, DRAIN, HOLD.
- IDLE -> STREAM when bank[rd_bank] full and res_valid == 0. seq_start pulses on that cycle.
- STREAM: cyc_cnt counts 0..STEP_CYCLES-1. At wrap, step_idx increments. At step SEQ_LEN-1 and cyc_cnt wrap -> DRAIN; free bank[rd_bank] and toggle rd_bank.
- x_t is registered, changes only at step boundaries, and is 0 in IDLE, DRAIN, HOLD.
- DRAIN: lat_cnt counts RESULT_LATENCY cycles. On the last count, capture y_t into res_data, set res_valid -> HOLD.
- HOLD -> IDLE immediately (one cycle). res_valid holds until res_valid && res_ready, then clears.
- The next sequence cannot start while res_valid is high. A result beat and a write-side fill may coincide freely.
- busy = STREAM or DRAIN.
- Same-cycle cases:
  - A bank freed by read in the same cycle the writer needs it: in_ready rises the next cycle.
  - res_ready with IDLE and a bank full: res_valid clears this cycle; the stream starts the next cycle.
- Total read latency: seq_start to res_valid = SEQ_LEN*STEP_CYCLES + RESULT_LATENCY + 1 = 298 cycles at defaults.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Package gru_feeder_pkg holds:
  - rd_state_t enum (IDLE, STREAM, DRAIN, HOLD)
  - feature_vec_t / result_vec_t array typedefs
  - default constants SEQ_LEN, STEP_CYCLES, RESULT_LATENCY
- Sub-module seq_pingpong_buf (2 x SEQ_LEN x X_SIZE register/BRAM banks with full flags, one write port, one read port). The FSMs live in the top.

Test Plan:
- One well-formed sequence (step k, feature j = k*16+j), res_ready=1, y_t tied to {1,2,3} -> seq_start once; x_t[0] = 0,16,...,224, each held 19 cycles; res_valid at cycle 298 with res_data {1,2,3}; seq_err never.
- Two back-to-back sequences with in_valid always high -> second bank fills during the first stream. in_ready drops after 30 beats until bank 0 frees. Second seq_start exactly 1 cycle after first res_valid handshake.
- in_last on 10th beat -> seq_err pulse; bank discarded; next full sequence streams normally starting at step_idx 0.
- res_ready=0 for 500 cycles with two sequences queued -> res_data stable; second stream does not start until res_ready pulse; no data lost.
- Async reset asserted mid-STREAM (step 7) -> all outputs 0 immediately without clock edge; banks empty; new sequence after release streams from step 0.
- 16 vectors with in_last only on the 16th -> seq_err on 15th beat; the 16th beat begins a new (partial) sequence.
